mdio_responder: RTL and testbench

- PHY-side Clause 22 MDIO management responder: the far end of the MAC's MDIO master and its host register interface.
- Oversamples MDC/MDIO on the system clock and decodes read/write frames addressed to its PHY address.
- Issues single-cycle register-bank strobes and drives read data back onto MDIO.
- Used as an on-chip PHY management model for loopback and for verification of the MDIO master.

---
 rtl/mdio_responder.sv | 180 ++++++++++++++++++
 tb/tb_mdio_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO on clk, decodes frames for phy_address,
// issues one-clk register strobes and serialises read data back onto MDIO.
module mdio_responder #(
  parameter int PREAMBLE_MIN = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic [4:0]  phy_address,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, CMD, TA_WR, WR_DATA, RD_TA, RD_DATA, SKIP} state_t;

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

  state_t                 state;
  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdio_sync;
  logic                   mdc_d;
  logic                   mdc_s;
  logic                   din;
  logic                   bit_event;
  logic [5:0]             pre_cnt;
  logic [4:0]             bit_cnt;
  logic [10:0]            cmd;
  logic [11:0]            cmd_next;
  logic [15:0]            shreg;
  logic [15:0]            wr_next;

  // Synchronizers track the pads continuously so reset never fabricates an MDC edge.
  always_ff @(posedge clk) begin
    mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc};
    mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_in};
    mdc_d     <= mdc_s;
  end

  assign mdc_s     = mdc_sync[SYNC_STAGES-1];
  assign din       = mdio_sync[SYNC_STAGES-1];
  assign bit_event = mdc_s & ~mdc_d;
  assign cmd_next  = {cmd, din};
  assign wr_next   = {shreg[14:0], din};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      cmd       <= '0;
      shreg     <= '0;
      mdio_out  <= 1'b1;
      mdio_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (reg_re) shreg <= reg_rdata;
      if (bit_event) begin
        case (state)
          IDLE: begin
            if (din) begin
              if (pre_cnt < PRE_MIN) pre_cnt <= pre_cnt + 6'd1;
            end else if (pre_cnt >= PRE_MIN) begin
              state <= START;
              busy  <= 1'b1;
            end else begin
              pre_cnt <= '0;
            end
          end
          START: begin
            if (din) begin
              state   <= CMD;
              bit_cnt <= '0;
            end else begin
              state   <= IDLE;
              pre_cnt <= '0;
              busy    <= 1'b0;
            end
          end
          CMD: begin
            cmd     <= cmd_next[10:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd11) begin
              bit_cnt <= '0;
              if (cmd_next[11:10] == 2'b00 || cmd_next[11:10] == 2'b11) begin
                state   <= IDLE;
                pre_cnt <= '0;
                busy    <= 1'b0;
              end else if (cmd_next[9:5] != phy_address) begin
                state <= SKIP;
              end else if (cmd_next[11:10] == 2'b01) begin
                state <= TA_WR;
              end else begin
                reg_re   <= 1'b1;
                reg_addr <= cmd_next[4:0];
                state    <= RD_TA;
              end
            end
          end
          TA_WR: begin
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              state   <= WR_DATA;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          WR_DATA: begin
            shreg <= wr_next;
            if (bit_cnt == 5'd15) begin
              reg_wdata <= wr_next;
              reg_addr  <= cmd[4:0];
              reg_we    <= 1'b1;
              bit_cnt   <= '0;
              state     <= IDLE;
              pre_cnt   <= '0;
              busy      <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          // Master samples Z on the first TA bit; we drive the 0 only on the second.
          RD_TA: begin
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
            end else begin
              mdio_oe  <= 1'b1;
              mdio_out <= 1'b0;
              bit_cnt  <= '0;
              state    <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (bit_cnt == 5'd16) begin
              mdio_oe  <= 1'b0;
              mdio_out <= 1'b1;
              bit_cnt  <= '0;
              state    <= IDLE;
              pre_cnt  <= '0;
              busy     <= 1'b0;
            end else begin
              mdio_out <= shreg[15];
              shreg    <= {shreg[14:0], 1'b0};
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
          SKIP: begin
            if (bit_cnt == 5'd17) begin
              bit_cnt <= '0;
              state   <= IDLE;
              pre_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: begin
            state   <= IDLE;
            pre_cnt <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: bit-banged MDIO master plus a strobe scoreboard.
module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  phy_address;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        busy;

  mdio_responder #(.PREAMBLE_MIN(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe), .phy_address(phy_address),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
  } strobe_t;

  strobe_t sb[$];
  strobe_t mon_e;
  int n_assert = 0;
  int n_fail   = 0;
  int oe_cycles = 0;
  int busy_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every pulse must match the next expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (mdio_oe) oe_cycles++;
      if (busy) busy_cycles++;
      if (reg_we || reg_re) begin
        check("we_re_exclusive", {31'b0, reg_we & reg_re}, 32'h0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'b0, reg_we, reg_re}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("strobe_kind", {31'b0, reg_we}, {31'b0, mon_e.we});
          check("strobe_addr", {27'b0, reg_addr}, {27'b0, mon_e.addr});
          if (mon_e.we) check("strobe_wdata", {16'b0, reg_wdata}, {16'b0, mon_e.data});
        end
      end
    end
  end

  task automatic bit_cycle(input logic b, output logic oe, output logic out, output logic bsy);
    @(negedge clk);
    mdio_in = b;
    mdc = 1'b0;
    repeat (8) @(negedge clk);
    mdc = 1'b1;
    repeat (6) @(negedge clk);
    oe  = mdio_oe;
    out = mdio_out;
    bsy = busy;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic b);
    logic oe, out, bsy;
    bit_cycle(b, oe, out, bsy);
  endtask

  task automatic send_n(input logic b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  task automatic send_field(input logic [15:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) send(v[i]);
  endtask

  task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                             input logic [15:0] data, input bit expect_hit);
    logic oe, out, bsy;
    if (expect_hit) sb.push_back('{1'b1, regad, data});
    oe_cycles = 0;
    busy_cycles = 0;
    send_n(1'b1, pre);
    send(1'b0); send(1'b1);
    send_field(16'b01, 2);
    send_field({11'b0, phy}, 5);
    send_field({11'b0, regad}, 5);
    send_field(16'b10, 2);
    send_field(data >> 1, 15);
    if (expect_hit) check("wr_we_early", sb.size(), 1);
    bit_cycle(data[0], oe, out, bsy);
    check("wr_busy_end", {31'b0, bsy}, 32'h0);
    check("wr_oe_quiet", oe_cycles, 0);
    if (expect_hit) check("wr_we_done", sb.size(), 0);
    else check("wr_ignored_busy", busy_cycles, 0);
  endtask

  task automatic read_frame(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] rdata, input bit expect_hit, input int n_data);
    logic oe, out, bsy;
    int k;
    reg_rdata = rdata;
    if (expect_hit) sb.push_back('{1'b0, regad, 16'h0});
    send_n(1'b1, pre);
    send(1'b0);
    bit_cycle(1'b1, oe, out, bsy);
    check("rd_busy_st", {31'b0, bsy}, 32'h1);
    send_field(16'b10, 2);
    send_field({11'b0, phy}, 5);
    send_field({12'b0, regad[4:1]}, 4);
    if (expect_hit) check("rd_re_early", sb.size(), 1);
    bit_cycle(regad[0], oe, out, bsy);
    if (expect_hit) check("rd_re_done", sb.size(), 0);
    bit_cycle(1'b1, oe, out, bsy);
    check("rd_ta0", {30'b0, oe, bsy}, 32'h1);
    bit_cycle(1'b1, oe, out, bsy);
    check("rd_ta1", {30'b0, oe, out}, expect_hit ? 32'h2 : 32'h1);
    for (int i = 15; i >= 16 - n_data; i--) begin
      bit_cycle(1'b0, oe, out, bsy);
      k = 18 - i;
      check("rd_data", {30'b0, oe, out}, expect_hit ? {30'b0, 1'b1, rdata[i]} : 32'h1);
      check("rd_busy", {31'b0, bsy}, {31'b0, (expect_hit || k < 18)});
    end
    if (expect_hit && n_data == 16) begin
      bit_cycle(1'b1, oe, out, bsy);
      check("rd_end", {29'b0, oe, out, bsy}, 32'h2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic oe, out, bsy;
    reset = 1'b1;
    mdc = 1'b0;
    mdio_in = 1'b1;
    phy_address = 5'h03;
    reg_rdata = 16'h0;
    repeat (5) @(negedge clk);
    check("rst_mdio", {30'b0, mdio_oe, mdio_out}, 32'h1);
    check("rst_strobes", {29'b0, reg_we, reg_re, busy}, 32'h0);
    check("rst_regs", {11'b0, reg_addr, reg_wdata}, 32'h0);
    reset = 1'b0;

    write_frame(32, 5'h03, 5'h04, 16'hA5C3, 1'b1);
    read_frame(32, 5'h03, 5'h1F, 16'h1234, 1'b1, 16);

    read_frame(32, 5'h07, 5'h1F, 16'h1234, 1'b0, 16);
    read_frame(32, 5'h03, 5'h11, 16'hBEEF, 1'b1, 16);

    write_frame(31, 5'h03, 5'h04, 16'hA5C3, 1'b0);
    write_frame(40, 5'h03, 5'h04, 16'hA5C3, 1'b1);

    send_n(1'b1, 32);
    send(1'b0);
    bit_cycle(1'b1, oe, out, bsy);
    check("op11_busy_st", {31'b0, bsy}, 32'h1);
    send_field(16'b11, 2);
    send_field(16'h03, 5);
    send_field(16'h02, 4);
    bit_cycle(1'b0, oe, out, bsy);
    check("op11_busy_drop", {31'b0, bsy}, 32'h0);

    write_frame(32, 5'h03, 5'h0A, 16'hFFFF, 1'b1);
    send_n(1'b1, 20);
    bit_cycle(1'b0, oe, out, bsy);
    check("no_false_start", {31'b0, bsy}, 32'h0);
    write_frame(32, 5'h03, 5'h05, 16'h0F0F, 1'b1);

    read_frame(32, 5'h03, 5'h02, 16'hC3A5, 1'b1, 8);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_mdio", {30'b0, mdio_oe, mdio_out}, 32'h1);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    mdc = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    read_frame(32, 5'h03, 5'h1F, 16'h1234, 1'b1, 16);

    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
